imem_loader: RTL and testbench

- Writer side of the instruction memory. Receives a framed byte stream over a valid/ready interface (e.g. from the UART receiver).
- Packs bytes into 32-bit little-endian words and drives a single-cycle write port into the instruction memory array.
- Holds the core in reset (cpu_hold) while a program is being loaded, and reports done or error on completion.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_word_packer.sv | 68 ++++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: frame start byte,
// word width, FSM state encoding and the checksum accumulate helper.
package imem_loader_pkg;

    localparam logic [7:0] START_BYTE = 8'hA5;
    localparam int         IMEM_DW    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4
    } state_e;

    // Running frame checksum is a plain byte-wise XOR.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream handshake into the loader. A byte moves when in_valid and
// in_ready are both high on a rising clock edge.
interface imem_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_word_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word and keeps the
// running XOR of every data byte since the last clear.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic               word_ready,
    output logic [IMEM_DW-1:0] word_o,
    output logic [7:0]         csum_o
);

    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [IMEM_DW-1:0] word_q, word_d, word_ins;
    logic [7:0]         csum_q, csum_d;

    // Current word with the incoming byte dropped into its lane.
    always_comb begin
        word_ins = word_q;
        case (byte_cnt_q)
            2'd0:    word_ins[7:0]   = byte_in;
            2'd1:    word_ins[15:8]  = byte_in;
            2'd2:    word_ins[23:16] = byte_in;
            2'd3:    word_ins[31:24] = byte_in;
            default: word_ins        = word_q;
        endcase
    end

    // Next-state for byte counter, word register and checksum.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        csum_d     = csum_q;
        if (clear) begin
            byte_cnt_d = 2'd0;
            word_d     = {IMEM_DW{1'b0}};
            csum_d     = 8'h00;
        end else if (byte_valid) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_d     = word_ins;
            csum_d     = csum_update(csum_q, byte_in);
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            word_q     <= {IMEM_DW{1'b0}};
            csum_q     <= 8'h00;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
        end
    end

    // The complete word is available combinationally as its top byte arrives.
    assign word_ready = byte_valid && !clear && (byte_cnt_q == 2'd3);
    assign word_o     = word_ins;
    assign csum_o     = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Frame receiver that writes a program into instruction memory.
// Frame: A5, N, 4N data bytes (LSB first), XOR checksum of the data bytes.
// The core is held in reset from the start byte until a frame is accepted.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int ADDR_W        = 3,
    parameter bit HOLD_AT_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    imem_loader_if.slave       bus,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [IMEM_DW-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_err
);

    localparam int         LEN_W   = ADDR_W + 1;
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [IMEM_DW-1:0] imem_wdata_q, imem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;

    logic               xfer;
    logic               len_ok;
    logic               last_word;
    logic               pack_clear;
    logic               pack_valid;
    logic               word_ready;
    logic [IMEM_DW-1:0] word_asm;
    logic [7:0]         csum_run;

    assign xfer       = bus.in_valid && in_ready_q;
    assign len_ok     = (bus.in_data != 8'h00) && (bus.in_data <= DEPTH_B);
    assign last_word  = ({1'b0, word_cnt_q} + {{ADDR_W{1'b0}}, 1'b1}) == len_q;
    assign pack_clear = xfer && (state_q == LEN) && len_ok;
    assign pack_valid = xfer && (state_q == DATA);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_in    (bus.in_data),
        .word_ready (word_ready),
        .word_o     (word_asm),
        .csum_o     (csum_run)
    );

    // Frame FSM: next state and next value of every registered output.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && (bus.in_data == START_BYTE)) begin
                    state_d    = LEN;
                    cpu_hold_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (len_ok) begin
                        len_d      = bus.in_data[LEN_W-1:0];
                        word_cnt_d = {ADDR_W{1'b0}};
                        state_d    = DATA;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    state_d = LEN;
                end
            end
            DATA: begin
                if (word_ready) begin
                    state_d      = WRITE;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_cnt_q;
                    imem_wdata_d = word_asm;
                end else begin
                    state_d = DATA;
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (last_word) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (bus.in_data == csum_run) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = CSUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The only cycle the loader refuses bytes is the memory write cycle.
        in_ready_d = (state_d != WRITE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= {LEN_W{1'b0}};
            word_cnt_q   <= {ADDR_W{1'b0}};
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= {IMEM_DW{1'b0}};
            cpu_hold_q   <= HOLD_AT_RESET;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frame, bad lengths, bad checksum,
// stalled stream with ready checking, and reset in the middle of a frame.
module tb_imem_loader;

    localparam bit HOLD = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [2:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_loader_if bus_if ();

    imem_loader #(.DEPTH(8), .ADDR_W(3), .HOLD_AT_RESET(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] tb_mem [0:7];
    logic [2:0]  wr_addr_log [0:15];
    logic [31:0] wr_data_log [0:15];
    bit          chk_ready = 1'b0;
    bit          stall_exp = 1'b0;
    logic [7:0]  frame_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mid-cycle observer: memory model, pulse counters and the ready rule.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            tb_mem[imem_addr] = imem_wdata;
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt] = imem_addr;
                wr_data_log[wr_cnt] = imem_wdata;
            end
            wr_cnt++;
        end
        if (load_done === 1'b1) done_cnt++;
        if (load_err === 1'b1) err_cnt++;
        if (chk_ready) check_eq("in_ready_stall", {31'd0, bus_if.in_ready}, {31'd0, !stall_exp});
        stall_exp = 1'b0;
    end

    // Offer one byte after 'gap' idle cycles; returns just after its transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit is4, input int gap);
        bit got;
        int k;
        bus_if.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus_if.in_data  = b;
        bus_if.in_valid = 1'b1;
        got = 1'b0;
        k   = 0;
        while (!got && k < 50) begin
            @(negedge clk);
            if (bus_if.in_ready === 1'b1) got = 1'b1;
            else k++;
        end
        if (got) begin
            @(posedge clk); #1;
            stall_exp = is4;
        end else begin
            check_eq("xfer_timeout", 32'd0, 32'd1);
        end
    endtask

    // Send frame_q[start..stop-1]; every 4th data byte is flagged for the ready check.
    task automatic send_frame(input int gapmax, input int start, input int stop);
        int gap;
        bit is4;
        for (int i = start; i < stop; i++) begin
            is4 = (i >= 2) && (i < frame_q.size() - 1) && (((i - 2) % 4) == 3);
            gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            send_byte(frame_q[i], is4, gap);
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_if.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        wr_cnt   = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic good_frame(input logic [7:0] csum);
        frame_q = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00, csum};
    endtask

    task automatic check_good_writes(input string p);
        check_eq({p, "_wrcnt"}, wr_cnt, 32'd2);
        check_eq({p, "_addr0"}, {29'd0, wr_addr_log[0]}, 32'd0);
        check_eq({p, "_data0"}, wr_data_log[0], 32'h0000_0013);
        check_eq({p, "_addr1"}, {29'd0, wr_addr_log[1]}, 32'd1);
        check_eq({p, "_data1"}, wr_data_log[1], 32'h0010_0093);
    endtask

    task automatic check_reset_outputs(input string p);
        check_eq({p, "_ready"}, {31'd0, bus_if.in_ready}, 32'd0);
        check_eq({p, "_we"},    {31'd0, imem_we}, 32'd0);
        check_eq({p, "_addr"},  {29'd0, imem_addr}, 32'd0);
        check_eq({p, "_wdata"}, imem_wdata, 32'd0);
        check_eq({p, "_hold"},  {31'd0, cpu_hold}, {31'd0, HOLD});
        check_eq({p, "_done"},  {31'd0, load_done}, 32'd0);
        check_eq({p, "_err"},   {31'd0, load_err}, 32'd0);
    endtask

    initial begin
        bus_if.in_data  = 8'h00;
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tb_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Good frame, no gaps.
        clr();
        good_frame(8'h90);
        send_frame(0, 0, 1);
        check_eq("hold_after_a5", {31'd0, cpu_hold}, 32'd1);
        send_frame(0, 1, frame_q.size());
        check_eq("good_done_pulse", {31'd0, load_done}, 32'd1);
        check_eq("good_hold_clear", {31'd0, cpu_hold}, 32'd0);
        idle(3);
        check_good_writes("good");
        check_eq("good_done_cnt", done_cnt, 32'd1);
        check_eq("good_err_cnt", err_cnt, 32'd0);

        // Length 0.
        clr();
        frame_q = '{8'hA5, 8'h00};
        send_frame(0, 0, 2);
        check_eq("len0_err_pulse", {31'd0, load_err}, 32'd1);
        idle(3);
        check_eq("len0_err_cnt", err_cnt, 32'd1);
        check_eq("len0_wr_cnt", wr_cnt, 32'd0);
        check_eq("len0_hold", {31'd0, cpu_hold}, 32'd1);

        // Length 9 exceeds DEPTH (also shows A5 is accepted again after an error).
        clr();
        frame_q = '{8'hA5, 8'h09};
        send_frame(0, 0, 2);
        check_eq("len9_err_pulse", {31'd0, load_err}, 32'd1);
        idle(3);
        check_eq("len9_err_cnt", err_cnt, 32'd1);
        check_eq("len9_wr_cnt", wr_cnt, 32'd0);
        check_eq("len9_done_cnt", done_cnt, 32'd0);
        check_eq("len9_hold", {31'd0, cpu_hold}, 32'd1);

        // Bad checksum: words still written, error reported, core stays held.
        clr();
        good_frame(8'h91);
        send_frame(0, 0, frame_q.size());
        check_eq("bad_err_pulse", {31'd0, load_err}, 32'd1);
        check_eq("bad_no_done", {31'd0, load_done}, 32'd0);
        idle(3);
        check_good_writes("bad");
        check_eq("bad_err_cnt", err_cnt, 32'd1);
        check_eq("bad_done_cnt", done_cnt, 32'd0);
        check_eq("bad_hold", {31'd0, cpu_hold}, 32'd1);

        // Good frame with random gaps; ready must drop exactly after each 4th data byte.
        clr();
        good_frame(8'h90);
        chk_ready = 1'b1;
        send_frame(3, 0, frame_q.size());
        check_eq("bp_done_pulse", {31'd0, load_done}, 32'd1);
        idle(3);
        chk_ready = 1'b0;
        check_good_writes("bp");
        check_eq("bp_done_cnt", done_cnt, 32'd1);
        check_eq("bp_err_cnt", err_cnt, 32'd0);
        check_eq("bp_hold", {31'd0, cpu_hold}, 32'd0);

        // Reset after the 6th byte of a frame.
        clr();
        for (int i = 0; i < 8; i++) tb_mem[i] = 32'd0;
        frame_q = '{8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                    8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_frame(0, 0, 6);
        check_eq("mid_hold", {31'd0, cpu_hold}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        check_eq("midrst_wr_cnt", wr_cnt, 32'd1);
        check_eq("midrst_word0", tb_mem[0], 32'hDEAD_BEEF);
        @(posedge clk); #1;
        rst = 1'b0;
        clr();
        good_frame(8'h90);
        send_frame(0, 0, frame_q.size());
        check_eq("post_done_pulse", {31'd0, load_done}, 32'd1);
        idle(3);
        check_good_writes("post");
        check_eq("post_mem1", tb_mem[1], 32'h0010_0093);
        check_eq("post_hold", {31'd0, cpu_hold}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
